pkt_cell_reader: RTL and testbench
==================================

Name: pkt_cell_reader

Overview:
- Read-side initiator on the packet buffer read port. It is instantiated once per TM TX path and once for the Deparser payload path.
- Accepts a packet's head cell ID and walks the cell linked list, issuing one read per cell.
- Streams each 64B cell out with sof/eof framing, then returns each emitted cell to the free list.
- Detects broken chains and over-length chains, and terminates the frame with an error flag.

Parameters:
CELL_ID_W, 20, cell ID width; the all-ones value is the end-of-list marker.
DATA_W, 512, cell payload width.
MAX_CELLS, 160, maximum cells per frame; a frame longer than this is aborted.

Ports:
clk_dp  in  1  datapath clock
rst_dp_n  in  1  async active-low reset
cmd_valid  in  1  start-frame request
cmd_ready  out  1  reader idle and able to accept a command
cmd_head_id  in  CELL_ID_W  first cell of the frame
rd_req_valid  out  1  buffer read request
rd_req_ready  in  1  buffer accepts the request
rd_req_cell_id  out  CELL_ID_W  cell being read
rd_rsp_valid  in  1  read response (exactly 1 cycle after the req handshake, no backpressure)
rd_rsp_data  in  DATA_W  cell payload
rd_rsp_next_cell_id  in  CELL_ID_W  next-pointer
rd_rsp_eof  in  1  last cell of the frame
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_data  out  DATA_W  cell payload
out_sof  out  1  first beat of the frame
out_eof  out  1  last beat of the frame
out_err  out  1  frame aborted (qualified by out_eof)
free_req  out  1  one-cycle pulse returning a cell
free_id  out  CELL_ID_W  cell being freed
pkt_cnt  out  32  completed frames; wraps at 2^32

Behaviour:
- Clock and reset: one clock, clk_dp; reset rst_dp_n is asynchronous, active-low.
- Reset values: all outputs 0 except cmd_ready=1. FSM returns to IDLE and cell_cnt=0.
- Reset mid-frame: the frame is dropped silently and no free is issued for the in-flight cell.
- FSM states: IDLE, ISSUE, WAIT_RSP, EMIT.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_head_id into cur_id, set first=1, cell_cnt=0, then go to ISSUE.
  - Command-to-request latency is 1 cycle.
- ISSUE: rd_req_valid=1 with rd_req_cell_id=cur_id, held stable until rd_req_ready. On the handshake, go to WAIT_RSP.
- WAIT_RSP:
  - On rd_rsp_valid, capture data, next, and eof into the output register, and go to EMIT.
  - rd_rsp_valid in any other state is ignored.
  - Only one request is outstanding at a time.
- EMIT: out_valid=1, out_sof=first.
  - out_eof = rsp_eof OR abort. out_err = abort.
  - abort = (rsp_eof==0 AND next==all-ones) OR (cell_cnt==MAX_CELLS-1 AND rsp_eof==0).
  - All out_* signals are held stable while out_ready=0.
  - On the out handshake:
    - free_req pulses for 1 cycle the next cycle, with free_id = the emitted cell.
    - first=0 and cell_cnt increments.
    - If out_eof: go to IDLE, and increment pkt_cnt only when out_err=0.
    - Otherwise: cur_id = next and go to ISSUE.
- Per-cell cost is a minimum of 3 cycles (ISSUE, WAIT_RSP, EMIT) with no stalls.
- Single-cell frame: out_sof=1 and out_eof=1 on the same beat.
- Abort does not free the unread remainder of the chain; software reclaims it.
- cell_cnt width: $clog2(MAX_CELLS+1).

Optional Feature:
- Macro: PKT_RD_FREE_EN.
- Defined: free_req and free_id behave as described above.
- Undefined: free_req and free_id are tied to 0. This is the multicast/replication mode, where the owner frees the cells. All other behaviour is identical.

Test Plan:
- Single-cell frame: cmd head=5; rsp eof=1, next=0xFFFFF.
  - Expect 1 beat with sof=1, eof=1, err=0.
  - With PKT_RD_FREE_EN: free_id=5.
  - pkt_cnt=1; rd_req_valid first asserted 1 cycle after the cmd handshake.
- Three-cell chain 10->11->12 (eof on 12).
  - Expect requests 10, 11, 12 in order and 3 beats with sof on 10 and eof on 12.
  - Expect frees 10, 11, 12; back-to-back beats 3 cycles apart.
- Backpressure: out_ready=0 for 4 cycles on beat 2, and rd_req_ready=0 for 2 cycles.
  - Outputs stay stable, and no request is outstanding while EMIT is blocked.
  - No extra frees; beat order is unchanged.
- Broken chain: head=7 with rsp eof=0, next=0xFFFFF.
  - Expect a beat with eof=1, err=1, then IDLE.
  - pkt_cnt is unchanged and free_id=7.
- Over-length chain with MAX_CELLS=4: a 6-cell chain.
  - The 4th beat has eof=1, err=1, and only 4 requests are issued.
- Mid-frame reset after beat 1: all outputs go to their reset values.
  - The next command runs normally.
  - Without PKT_RD_FREE_EN, free_req stays 0 throughout.

Source files
------------

// File: rtl/pkt_cell_reader.sv
// pkt_cell_reader: read-side initiator on the packet buffer read port.
// It walks a packet's cell linked list from its head cell, issuing one read
// per cell. Each 64B cell is streamed out as one beat with sof/eof framing.
// A chain that ends without eof, or that runs past MAX_CELLS, is terminated
// early with out_err set on the eof beat.
//
// Build option:
//   PKT_RD_FREE_EN - when defined, each emitted cell is returned to the free
//                    list via a one-cycle free_req pulse. When undefined
//                    (multicast/replication mode), free_req and free_id are
//                    tied to 0, because the owner frees the cells.
//
// Ports:
//   clk_dp, rst_dp_n           datapath clock, async active-low reset
//   cmd_valid/ready/head_id    start-frame command (ready only while idle)
//   rd_req_valid/ready/cell_id buffer read request, one outstanding at a time
//   rd_rsp_valid/data/next_cell_id/eof
//                              read response, one cycle after the request
//   out_valid/ready/data/sof/eof/err
//                              cell beat stream toward downstream
//   free_req/free_id           cell return pulse, one cycle after the beat handshake
//   pkt_cnt                    count of frames completed without error
module pkt_cell_reader #(
  parameter int unsigned CELL_ID_W = 20,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_CELLS = 160
) (
  input  logic                 clk_dp,
  input  logic                 rst_dp_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CELL_ID_W-1:0] cmd_head_id,
  output logic                 rd_req_valid,
  input  logic                 rd_req_ready,
  output logic [CELL_ID_W-1:0] rd_req_cell_id,
  input  logic                 rd_rsp_valid,
  input  logic [DATA_W-1:0]    rd_rsp_data,
  input  logic [CELL_ID_W-1:0] rd_rsp_next_cell_id,
  input  logic                 rd_rsp_eof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 out_err,
  output logic                 free_req,
  output logic [CELL_ID_W-1:0] free_id,
  output logic [31:0]          pkt_cnt
);

  localparam int unsigned          CNT_W    = $clog2(MAX_CELLS + 1);
  localparam logic [CELL_ID_W-1:0] END_ID   = '1;
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(MAX_CELLS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, EMIT} state_t;

  state_t               state;
  logic [CELL_ID_W-1:0] cur_id;
  logic [CELL_ID_W-1:0] nxt_id;
  logic                 first;
  logic [CNT_W-1:0]     cell_cnt;
  logic                 abort_c;

  // cur_id stays put from ISSUE through EMIT, so it doubles as the request ID
  assign rd_req_cell_id = cur_id;

  // Abort when the chain ends without eof, or when this would be the last allowed cell
  assign abort_c = !rd_rsp_eof &&
                   ((rd_rsp_next_cell_id == END_ID) || (cell_cnt == LAST_CNT));

  // Chain-walk FSM; every output is registered here
  always_ff @(posedge clk_dp or negedge rst_dp_n) begin
    if (!rst_dp_n) begin
      state        <= IDLE;
      cur_id       <= '0;
      nxt_id       <= '0;
      first        <= 1'b0;
      cell_cnt     <= '0;
      cmd_ready    <= 1'b1;
      rd_req_valid <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
      out_err      <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_id       <= cmd_head_id;
            first        <= 1'b1;
            cell_cnt     <= '0;
            cmd_ready    <= 1'b0;
            rd_req_valid <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (rd_req_ready) begin
            rd_req_valid <= 1'b0;
            state        <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rd_rsp_valid) begin
            out_valid <= 1'b1;
            out_data  <= rd_rsp_data;
            nxt_id    <= rd_rsp_next_cell_id;
            out_sof   <= first;
            out_eof   <= rd_rsp_eof | abort_c;
            out_err   <= abort_c;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
            first     <= 1'b0;
            cell_cnt  <= cell_cnt + CNT_W'(1);
            if (out_eof) begin
              cmd_ready <= 1'b1;
              state     <= IDLE;
              if (!out_err) begin
                pkt_cnt <= pkt_cnt + 32'd1;
              end
            end else begin
              cur_id       <= nxt_id;
              rd_req_valid <= 1'b1;
              state        <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PKT_RD_FREE_EN
  // Return the emitted cell one cycle after its beat is accepted
  always_ff @(posedge clk_dp or negedge rst_dp_n) begin
    if (!rst_dp_n) begin
      free_req <= 1'b0;
      free_id  <= '0;
    end else begin
      free_req <= (state == EMIT) && out_ready;
      if ((state == EMIT) && out_ready) begin
        free_id <= cur_id;
      end
    end
  end
`else
  // Replication mode: the owner of the cells returns them
  assign free_req = 1'b0;
  assign free_id  = '0;
`endif

endmodule

// File: tb/tb_pkt_cell_reader.sv
// tb_pkt_cell_reader: directed self-checking bench for pkt_cell_reader.
// A negedge process models the buffer, which answers one cycle after each
// request handshake from a small linked-list table. The same process applies
// the out/req stalls and logs requests, beats and frees. The main sequence
// runs directed frames and compares each log against hand-written
// expectations. The DUT is built with MAX_CELLS=4 to reach the over-length
// abort.
module tb_pkt_cell_reader;

  localparam int unsigned IDW  = 20;
  localparam int unsigned DW   = 512;
  localparam int unsigned MAXC = 4;
  localparam int          END  = 32'hFFFFF;

  logic           clk_dp = 1'b0;
  logic           rst_dp_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IDW-1:0] cmd_head_id = '0;
  logic           rd_req_valid;
  logic           rd_req_ready = 1'b0;
  logic [IDW-1:0] rd_req_cell_id;
  logic           rd_rsp_valid = 1'b0;
  logic [DW-1:0]  rd_rsp_data = '0;
  logic [IDW-1:0] rd_rsp_next_cell_id = '0;
  logic           rd_rsp_eof = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  out_data;
  logic           out_sof;
  logic           out_eof;
  logic           out_err;
  logic           free_req;
  logic [IDW-1:0] free_id;
  logic [31:0]    pkt_cnt;

  pkt_cell_reader #(.CELL_ID_W(IDW), .DATA_W(DW), .MAX_CELLS(MAXC)) dut (
    .clk_dp(clk_dp), .rst_dp_n(rst_dp_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_head_id(cmd_head_id),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_cell_id(rd_req_cell_id),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .rd_rsp_next_cell_id(rd_rsp_next_cell_id), .rd_rsp_eof(rd_rsp_eof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .out_err(out_err),
    .free_req(free_req), .free_id(free_id), .pkt_cnt(pkt_cnt)
  );

  always #5 clk_dp = ~clk_dp;

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
    logic          err;
    int            cyc;
  } beat_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Buffer model: next pointer and eof flag per cell
  int nxt_mem[int];
  bit eof_mem[int];

  int    exp_ids[$];
  int    req_q[$];
  int    free_q[$];
  beat_t beat_q[$];

  int       cyc = 0;
  int       req_n = 0;
  int       beat_n = 0;
  int       stall_beat = -1;
  int       stall_left = 0;
  int       req_stall_idx = -1;
  int       req_stall_left = 0;
  int       blk_out_n = 0;
  int       blk_req_n = 0;
  bit       frame_done = 1'b0;
  bit       rsp_pend = 1'b0;
  int       rsp_id = 0;
  bit       prev_out_blk = 1'b0;
  bit       prev_req_blk = 1'b0;
  logic [63:0] prev_data = '0;
  logic [2:0]  prev_flags = '0;
  logic [IDW-1:0] prev_req_id = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] data_of(input int id);
    data_of = {16{32'hC0DE_0000 ^ 32'(id)}};
  endfunction

  // Buffer responder, stall injection and event logging, all at negedge
  initial begin
    forever begin
      @(negedge clk_dp);
      cyc++;
      if (rsp_pend && rst_dp_n) begin
        rd_rsp_valid        = 1'b1;
        rd_rsp_data         = data_of(rsp_id);
        rd_rsp_next_cell_id = nxt_mem.exists(rsp_id) ? IDW'(nxt_mem[rsp_id]) : IDW'(END);
        rd_rsp_eof          = eof_mem.exists(rsp_id) ? eof_mem[rsp_id] : 1'b1;
      end else begin
        rd_rsp_valid        = 1'b0;
        rd_rsp_data         = '0;
        rd_rsp_next_cell_id = '0;
        rd_rsp_eof          = 1'b0;
      end
      rd_req_ready = 1'b1;
      if (rd_req_valid && req_n == req_stall_idx && req_stall_left > 0) begin
        rd_req_ready = 1'b0;
        req_stall_left--;
        blk_req_n++;
      end
      out_ready = 1'b1;
      if (out_valid && beat_n == stall_beat && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        blk_out_n++;
      end
      if (prev_out_blk) begin
        check("out_hold_valid", 64'(out_valid), 64'd1);
        check("out_hold_data", out_data[63:0], prev_data);
        check("out_hold_flags", 64'({out_sof, out_eof, out_err}), 64'(prev_flags));
        check("no_req_while_blocked", 64'(rd_req_valid), 64'd0);
      end
      if (prev_req_blk) begin
        check("req_hold_valid", 64'(rd_req_valid), 64'd1);
        check("req_hold_id", 64'(rd_req_cell_id), 64'(prev_req_id));
      end
      rsp_pend = rst_dp_n && rd_req_valid && rd_req_ready;
      if (rsp_pend) begin
        rsp_id = int'(rd_req_cell_id);
        req_q.push_back(rsp_id);
        req_n++;
      end
      if (rst_dp_n && out_valid && out_ready) begin
        beat_t b;
        b.data = out_data;
        b.sof  = out_sof;
        b.eof  = out_eof;
        b.err  = out_err;
        b.cyc  = cyc;
        beat_q.push_back(b);
        beat_n++;
        if (out_eof) frame_done = 1'b1;
      end
      if (free_req) free_q.push_back(int'(free_id));
      prev_out_blk = out_valid && !out_ready;
      prev_req_blk = rd_req_valid && !rd_req_ready;
      prev_data    = out_data[63:0];
      prev_flags   = {out_sof, out_eof, out_err};
      prev_req_id  = rd_req_cell_id;
    end
  end

  task automatic clear_mon();
    req_q.delete();
    free_q.delete();
    beat_q.delete();
    exp_ids.delete();
    req_n = 0;
    beat_n = 0;
    blk_out_n = 0;
    blk_req_n = 0;
    stall_beat = -1;
    stall_left = 0;
    req_stall_idx = -1;
    req_stall_left = 0;
    frame_done = 1'b0;
  endtask

  task automatic send_cmd(input int head);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid   = 1'b1;
    cmd_head_id = IDW'(head);
    @(posedge clk_dp);
    #1;
    cmd_valid = 1'b0;
    check("req_latency", 64'(rd_req_valid), 64'd1);
    check("req_first_id", 64'(rd_req_cell_id), 64'(head));
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!frame_done && c < 200) begin
      @(posedge clk_dp);
      c++;
    end
    check(tag, 64'(frame_done), 64'd1);
    repeat (3) @(posedge clk_dp);
    #2;
  endtask

  task automatic check_frame(input bit exp_err);
    int n_exp = exp_ids.size();
    logic [DW-1:0] d;
    check("req_count", 64'(req_q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < req_q.size(); i++)
      check("req_id", 64'(req_q[i]), 64'(exp_ids[i]));
    check("beat_count", 64'(beat_q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < beat_q.size(); i++) begin
      d = data_of(exp_ids[i]);
      check("beat_data_lo", beat_q[i].data[63:0], d[63:0]);
      check("beat_data_hi", beat_q[i].data[DW-1:DW-64], d[DW-1:DW-64]);
      check("beat_sof", 64'(beat_q[i].sof), 64'(i == 0));
      check("beat_eof", 64'(beat_q[i].eof), 64'(i == n_exp - 1));
      check("beat_err", 64'(beat_q[i].err), 64'(exp_err && (i == n_exp - 1)));
    end
`ifdef PKT_RD_FREE_EN
    check("free_count", 64'(free_q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < free_q.size(); i++)
      check("free_id", 64'(free_q[i]), 64'(exp_ids[i]));
`else
    check("free_none", 64'(free_q.size()), 64'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_req_valid"}, 64'(rd_req_valid), 64'd0);
    check({tag, "_req_id"}, 64'(rd_req_cell_id), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_flags"}, 64'({out_sof, out_eof, out_err}), 64'd0);
    check({tag, "_out_data"}, out_data[63:0], 64'd0);
    check({tag, "_free_req"}, 64'(free_req), 64'd0);
    check({tag, "_free_id"}, 64'(free_id), 64'd0);
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
  endtask

  initial begin
    int c;
    repeat (2) @(posedge clk_dp);
    #1;
    check_reset_outputs("rst");
    #1;
    rst_dp_n = 1'b1;
    @(posedge clk_dp);
    #2;

    // Single-cell frame
    clear_mon();
    nxt_mem[5] = END; eof_mem[5] = 1'b1;
    exp_ids = '{5};
    send_cmd(5);
    wait_done("single_done");
    check_frame(1'b0);
    check("single_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Three-cell chain, no stalls
    clear_mon();
    nxt_mem[10] = 11; eof_mem[10] = 1'b0;
    nxt_mem[11] = 12; eof_mem[11] = 1'b0;
    nxt_mem[12] = END; eof_mem[12] = 1'b1;
    exp_ids = '{10, 11, 12};
    send_cmd(10);
    wait_done("chain_done");
    check_frame(1'b0);
    if (beat_q.size() == 3) begin
      check("beat_gap_1", 64'(beat_q[1].cyc - beat_q[0].cyc), 64'd3);
      check("beat_gap_2", 64'(beat_q[2].cyc - beat_q[1].cyc), 64'd3);
    end else begin
      check("beat_gap_count", 64'(beat_q.size()), 64'd3);
    end
    check("chain_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // Backpressure on beat 2 and on the second read request
    clear_mon();
    nxt_mem[20] = 21; eof_mem[20] = 1'b0;
    nxt_mem[21] = 22; eof_mem[21] = 1'b0;
    nxt_mem[22] = END; eof_mem[22] = 1'b1;
    exp_ids = '{20, 21, 22};
    stall_beat = 1; stall_left = 4;
    req_stall_idx = 1; req_stall_left = 2;
    send_cmd(20);
    wait_done("bp_done");
    check_frame(1'b0);
    check("bp_out_stalls", 64'(blk_out_n), 64'd4);
    check("bp_req_stalls", 64'(blk_req_n), 64'd2);
    check("bp_pkt_cnt", 64'(pkt_cnt), 64'd3);

    // Broken chain: no eof, but next is the end marker
    clear_mon();
    nxt_mem[7] = END; eof_mem[7] = 1'b0;
    exp_ids = '{7};
    send_cmd(7);
    wait_done("broken_done");
    check_frame(1'b1);
    check("broken_pkt_cnt", 64'(pkt_cnt), 64'd3);
    check("broken_idle", 64'(cmd_ready), 64'd1);

    // Over-length: a 6-cell chain with MAX_CELLS=4 stops after 4 reads
    clear_mon();
    for (int i = 30; i < 35; i++) begin
      nxt_mem[i] = i + 1; eof_mem[i] = 1'b0;
    end
    nxt_mem[35] = END; eof_mem[35] = 1'b1;
    exp_ids = '{30, 31, 32, 33};
    send_cmd(30);
    wait_done("long_done");
    check_frame(1'b1);
    check("long_pkt_cnt", 64'(pkt_cnt), 64'd3);

    // Reset while the second beat of a frame is pending
    clear_mon();
    nxt_mem[40] = 41; eof_mem[40] = 1'b0;
    nxt_mem[41] = 42; eof_mem[41] = 1'b0;
    nxt_mem[42] = END; eof_mem[42] = 1'b1;
    send_cmd(40);
    c = 0;
    while (beat_n < 1 && c < 100) begin
      @(posedge clk_dp);
      c++;
    end
    check("mid_beat1_seen", 64'(beat_n), 64'd1);
    @(posedge clk_dp);
    @(posedge clk_dp);
    #1;
    check("mid_pre_rst_emit", 64'(out_valid), 64'd1);
    rst_dp_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk_dp);
    #2;
    rst_dp_n = 1'b1;
    repeat (3) @(posedge clk_dp);
    #2;
    check("mid_req_count", 64'(req_q.size()), 64'd2);
`ifdef PKT_RD_FREE_EN
    check("mid_free_count", 64'(free_q.size()), 64'd1);
    if (free_q.size() > 0) check("mid_free_id", 64'(free_q[0]), 64'd40);
`else
    check("mid_free_none", 64'(free_q.size()), 64'd0);
`endif

    // Normal frame after the reset
    clear_mon();
    exp_ids = '{5};
    send_cmd(5);
    wait_done("post_rst_done");
    check_frame(1'b0);
    check("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
